sr_pulse_ctrl: RTL and testbench

Upstream driver for the team's cross-coupled NAND SR latch, which has active-low S and R inputs and a forbidden state when both are low. The block takes two raw, asynchronous, bouncy request lines (set and reset). It synchronizes and debounces them, then turns each accepted rising edge into a registered active-low pulse of fixed width on S_n or R_n. S_n and R_n are never driven low at the same time, and a guard cycle separates consecutive pulses.

---
 rtl/sr_pulse_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sr_pulse_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sr_pulse_ctrl.sv
// sr_pulse_ctrl: sync + debounce two raw requests, drive NAND SR latch pulses.
// Optional macro SRPC_DEBOUNCE_EN enables the debounce stage.
module sr_pulse_ctrl #(
   parameter int DEB_CYCLES = 4,
   parameter int PULSE_W    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic rst_req,
   output logic S_n,
   output logic R_n,
   output logic busy,
   output logic conflict,
   output logic dropped
);

   typedef enum logic [1:0] {
      IDLE,
      SET_P,
      RST_P,
      GAP
   } state_t;

   localparam int PW_W = $clog2(PULSE_W + 1);
   localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_W - 1);

   if (DEB_CYCLES < 1 || PULSE_W < 1) begin : g_param_chk
      $error("sr_pulse_ctrl: DEB_CYCLES and PULSE_W must be >= 1");
   end

   logic set_s1, set_s2, rst_s1, rst_s2;
   logic sync_set, sync_rst;
   logic acc_set, acc_rst;
   logic set_d, rst_d;
   logic ev_set, ev_rst;

   state_t          state, state_n;
   logic [PW_W-1:0] pcnt, pcnt_n;
   logic            conflict_n, dropped_n;

   // two-flop synchronizers for the raw request lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_s1 <= 1'b0;
         set_s2 <= 1'b0;
         rst_s1 <= 1'b0;
         rst_s2 <= 1'b0;
      end else begin
         set_s1 <= set_req;
         set_s2 <= set_s1;
         rst_s1 <= rst_req;
         rst_s2 <= rst_s1;
      end
   end

   assign sync_set = set_s2;
   assign sync_rst = rst_s2;

`ifdef SRPC_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEB_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEB_CYCLES - 1);

   logic [DB_W-1:0] set_cnt, rst_cnt;

   // accept a level only after DEB_CYCLES consecutive mismatching cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_set <= 1'b0;
         acc_rst <= 1'b0;
         set_cnt <= '0;
         rst_cnt <= '0;
      end else begin
         if (sync_set == acc_set) begin
            set_cnt <= '0;
         end else if (set_cnt >= DB_LAST) begin
            acc_set <= sync_set;
            set_cnt <= '0;
         end else begin
            set_cnt <= set_cnt + 1'b1;
         end
         if (sync_rst == acc_rst) begin
            rst_cnt <= '0;
         end else if (rst_cnt >= DB_LAST) begin
            acc_rst <= sync_rst;
            rst_cnt <= '0;
         end else begin
            rst_cnt <= rst_cnt + 1'b1;
         end
      end
   end
`else
   assign acc_set = sync_set;
   assign acc_rst = sync_rst;
`endif

   // delayed copies of the accepted levels for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         set_d <= 1'b0;
         rst_d <= 1'b0;
      end else begin
         set_d <= acc_set;
         rst_d <= acc_rst;
      end
   end

   assign ev_set = acc_set & ~set_d;
   assign ev_rst = acc_rst & ~rst_d;

   // state, pulse counter and registered latch drives / strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pcnt     <= '0;
         S_n      <= 1'b1;
         R_n      <= 1'b1;
         conflict <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         state    <= state_n;
         pcnt     <= pcnt_n;
         S_n      <= (state_n != SET_P);
         R_n      <= (state_n != RST_P);
         conflict <= conflict_n;
         dropped  <= dropped_n;
      end
   end

   // next-state: one pulse per accepted edge, then a guard cycle
   always_comb begin
      state_n    = state;
      pcnt_n     = pcnt;
      conflict_n = 1'b0;
      dropped_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (ev_set && ev_rst) begin
               conflict_n = 1'b1;
            end else if (ev_set) begin
               state_n = SET_P;
               pcnt_n  = PW_LAST;
            end else if (ev_rst) begin
               state_n = RST_P;
               pcnt_n  = PW_LAST;
            end
         end
         SET_P, RST_P: begin
            dropped_n = ev_set | ev_rst;
            if (pcnt == '0) begin
               state_n = GAP;
            end else begin
               pcnt_n = pcnt - 1'b1;
            end
         end
         GAP: begin
            dropped_n = ev_set | ev_rst;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_pulse_ctrl.sv
// tb_sr_pulse_ctrl: directed checks of sr_pulse_ctrl latency and guards.
// Follows SRPC_DEBOUNCE_EN to pick the expected debounce latency.
module tb_sr_pulse_ctrl;

   localparam int DEB = 4;
   localparam int PW  = 2;
`ifdef SRPC_DEBOUNCE_EN
   localparam int D = DEB;
`else
   localparam int D = 0;
`endif
   localparam int LAT = 3 + D;

   logic clk = 1'b0;
   logic rst;
   logic set_req, rst_req;
   logic S_n, R_n, busy, conflict, dropped;

   int checks   = 0;
   int failures = 0;

   sr_pulse_ctrl #(
      .DEB_CYCLES(DEB),
      .PULSE_W   (PW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .set_req (set_req),
      .rst_req (rst_req),
      .S_n     (S_n),
      .R_n     (R_n),
      .busy    (busy),
      .conflict(conflict),
      .dropped (dropped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // drop both requests and let everything settle back to idle
   task automatic go_idle();
      set_req = 1'b0;
      rst_req = 1'b0;
      repeat (2 * D + 8) tick();
   endtask

   // caller has just raised the request; next edge is edge 1
   task automatic run_pulse(input bit is_set, input string tag);
      bit lo;
      for (int k = 1; k <= LAT + PW + 2; k++) begin
         tick();
         lo = (k >= LAT) && (k < LAT + PW);
         check($sformatf("%s_Sn_k%0d", tag, k), S_n, !(lo && is_set));
         check($sformatf("%s_Rn_k%0d", tag, k), R_n, !(lo && !is_set));
         check($sformatf("%s_busy_k%0d", tag, k), busy,
               (k >= LAT) && (k < LAT + PW + 1));
         check($sformatf("%s_drop_k%0d", tag, k), dropped, 1'b0);
      end
   endtask

   initial begin
      set_req = 1'b0;
      rst_req = 1'b0;
      rst     = 1'b1;
      repeat (2) tick();
      check("rst_Sn", S_n, 1'b1);
      check("rst_Rn", R_n, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_conf", conflict, 1'b0);
      check("rst_drop", dropped, 1'b0);
      rst = 1'b0;
      repeat (3) tick();

      // single set pulse
      set_req = 1'b1;
      run_pulse(1'b1, "set");
      // falling edge of the request must not pulse
      set_req = 1'b0;
      for (int k = 1; k <= D + 6; k++) begin
         tick();
         check($sformatf("fall_Sn_k%0d", k), S_n, 1'b1);
         check($sformatf("fall_busy_k%0d", k), busy, 1'b0);
      end
      go_idle();

`ifdef SRPC_DEBOUNCE_EN
      // bounce: sampled H,H,H,L then steady H from edge 5
      set_req = 1'b1;
      for (int k = 1; k <= 9 + D + PW + 2; k++) begin
         tick();
         check($sformatf("bnc_Sn_k%0d", k), S_n,
               !((k >= 7 + D) && (k < 7 + D + PW)));
         check($sformatf("bnc_busy_k%0d", k), busy,
               (k >= 7 + D) && (k < 8 + D + PW));
         check($sformatf("bnc_Rn_k%0d", k), R_n, 1'b1);
         set_req = (k + 1 != 4);
      end
      go_idle();
`endif

      // simultaneous set and reset
      set_req = 1'b1;
      rst_req = 1'b1;
      for (int k = 1; k <= LAT + PW + 3; k++) begin
         tick();
         check($sformatf("cnf_conf_k%0d", k), conflict, k == LAT);
         check($sformatf("cnf_Sn_k%0d", k), S_n, 1'b1);
         check($sformatf("cnf_Rn_k%0d", k), R_n, 1'b1);
         check($sformatf("cnf_busy_k%0d", k), busy, 1'b0);
      end
      go_idle();

      // reset request lands while set pulse is active
      set_req = 1'b1;
      for (int k = 1; k <= LAT + PW + 3; k++) begin
         tick();
         check($sformatf("drp_drop_k%0d", k), dropped, k == LAT + 1);
         check($sformatf("drp_Rn_k%0d", k), R_n, 1'b1);
         check($sformatf("drp_Sn_k%0d", k), S_n,
               !((k >= LAT) && (k < LAT + PW)));
         check($sformatf("drp_conf_k%0d", k), conflict, 1'b0);
         if (k == 1) rst_req = 1'b1;
      end
      go_idle();
      rst_req = 1'b1;
      run_pulse(1'b0, "rstp");
      go_idle();

      // asynchronous reset in the middle of a set pulse
      set_req = 1'b1;
      repeat (LAT) tick();
      check("arst_pre_Sn", S_n, 1'b0);
      #2;
      rst     = 1'b1;
      set_req = 1'b0;
      #1;
      check("arst_Sn", S_n, 1'b1);
      check("arst_Rn", R_n, 1'b1);
      check("arst_busy", busy, 1'b0);
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 2 * D + 8; k++) begin
         tick();
         check($sformatf("arst_idle_Sn_k%0d", k), S_n, 1'b1);
         check($sformatf("arst_idle_busy_k%0d", k), busy, 1'b0);
      end
      set_req = 1'b1;
      run_pulse(1'b1, "arst_new");
      go_idle();

      // random bouncing requests never drive both latch inputs low
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) set_req = ~set_req;
         if ($urandom_range(0, 3) == 0) rst_req = ~rst_req;
         tick();
         check("rnd_never_both_low", S_n | R_n, 1'b1);
      end
      go_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
